// File: rtl/clk_gen_pkg.sv
// Shared constants, per-channel configuration layout and sizing helper
// for the NCO clock-enable bank.
package clk_gen_pkg;

  localparam int ACC_W_DEF       = 24;
  localparam int LOCK_CYCLES_DEF = 16;

  typedef struct packed {
    logic [ACC_W_DEF-1:0] inc;
    logic [ACC_W_DEF-1:0] inc_shadow;
    logic [ACC_W_DEF-1:0] phase;
    logic                 pending;
  } ch_cfg_t;

  // Channel-select width, never narrower than one bit.
  function automatic int ch_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/clk_gen_nco_ch.sv
// One NCO channel: phase accumulator, shadowed increment that is swapped in
// only at a wrap (or immediately when idle), and tick/square outputs.
module clk_gen_nco_ch
  import clk_gen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic [ACC_W-1:0] wr_phase,
  output logic             clk_en,
  output logic             clk_sq,
  output logic             pending
);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] inc_r;
  logic [ACC_W-1:0] shadow_r;
  logic [ACC_W-1:0] phase_r;
  logic             pending_r;
  logic             clk_en_r;

  logic [ACC_W:0]   sum_s;
  logic             carry_s;
  logic             apply_s;

  // Accumulator sum, wrap carry and the decision to retire a pending increment.
  always_comb begin
    sum_s   = {1'b0, acc_r} + {1'b0, inc_r};
    carry_s = sum_s[ACC_W];
    if (pending_r && (!en || (inc_r == {ACC_W{1'b0}}) || carry_s)) begin
      apply_s = 1'b1;
    end else begin
      apply_s = 1'b0;
    end
  end

  // Channel state; a same-cycle write is folded into the sync realignment.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= {ACC_W{1'b0}};
      inc_r     <= {ACC_W{1'b0}};
      shadow_r  <= {ACC_W{1'b0}};
      phase_r   <= {ACC_W{1'b0}};
      pending_r <= 1'b0;
      clk_en_r  <= 1'b0;
    end else if (sync) begin
      acc_r     <= wr ? wr_phase : phase_r;
      inc_r     <= wr ? wr_inc   : shadow_r;
      pending_r <= 1'b0;
      clk_en_r  <= 1'b0;
      if (wr) begin
        shadow_r <= wr_inc;
        phase_r  <= wr_phase;
      end
    end else begin
      if (en) begin
        acc_r    <= sum_s[ACC_W-1:0];
        clk_en_r <= carry_s;
      end else begin
        clk_en_r <= 1'b0;
      end
      // The wrapping edge still advances with the old increment.
      if (wr) begin
        shadow_r  <= wr_inc;
        phase_r   <= wr_phase;
        pending_r <= 1'b1;
      end else if (apply_s) begin
        inc_r     <= shadow_r;
        pending_r <= 1'b0;
      end
    end
  end

  assign clk_en  = clk_en_r;
  assign clk_sq  = acc_r[ACC_W-1];
  assign pending = pending_r;

endmodule

// File: rtl/clk_gen_nco_bank.sv
// Bank of NUM_CH programmable NCO clock-enable generators with shared
// configuration port, sync realignment and a lock indicator.
module clk_gen_nco_bank
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH      = 9,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic              cfg_err,
  input  logic              sync_req,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_sq,
  output logic [NUM_CH-1:0] pending,
  output logic              locked
);

  localparam int             CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_L = CNT_W'(LOCK_CYCLES);
  localparam logic [CH_W:0]  NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic              in_range_s;
  logic              cfg_valid_s;
  logic [NUM_CH-1:0] wr_s;
  logic              cfg_err_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              locked_r;

  // Configuration address decode.
  always_comb begin
    in_range_s = ({1'b0, cfg_ch} < NUM_CH_L);
    if (cfg_we && in_range_s) begin
      cfg_valid_s = 1'b1;
    end else begin
      cfg_valid_s = 1'b0;
    end
  end

  // Out-of-range write flag, one cycle after the strobe.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_we && !in_range_s;
    end
  end

  // Saturating lock count.
  always_comb begin
    if (cnt_r == LOCK_L) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Lock counter and flag; sync restarts the settling window.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      locked_r <= 1'b0;
    end else if (sync_req) begin
      cnt_r    <= {CNT_W{1'b0}};
      locked_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      locked_r <= (cnt_nxt_s == LOCK_L);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_s[c] = cfg_valid_s && (cfg_ch == CH_W'(c));

    clk_gen_nco_ch #(
      .ACC_W (ACC_W)
    ) u_ch (
      .refclk   (refclk),
      .rst_n    (rst_n),
      .en       (ch_en[c]),
      .sync     (sync_req),
      .wr       (wr_s[c]),
      .wr_inc   (cfg_inc),
      .wr_phase (cfg_phase),
      .clk_en   (clk_en[c]),
      .clk_sq   (clk_sq[c]),
      .pending  (pending[c])
    );
  end

  assign cfg_err = cfg_err_r;
  assign locked  = locked_r;

endmodule
